// File: rtl/hmc_pfch_rd_arb.sv
// hmc_pfch_rd_arb: round-robin burst arbiter merging prefetch read streams into one registered output stream
module hmc_pfch_rd_arb #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int BLEN_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int PORT_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_vld,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ack,
  input  logic [BLEN_W-1:0]           cfg_burst_len,
  output logic                        out_vld,
  output logic [DATA_W-1:0]           out_data,
  output logic [PORT_W-1:0]           out_src,
  output logic                        out_last,
  input  logic                        out_rdy,
  output logic                        busy,
  output logic                        err_timeout
);
  localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;
  state_t state_q, state_d;
  logic [PORT_W-1:0] gnt_q, gnt_d, rr_q, rr_d, src_q, src_d, pick, nxt;
  logic [BLEN_W-1:0] blen_q, blen_d, beat_q, beat_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic load, gv, xfer, is_last, tmo;
  int off, best;
  assign load    = ~vld_q | out_rdy;
  assign gv      = in_vld[gnt_q];
  assign xfer    = state_q == BURST && gv && load;
  assign is_last = beat_q == blen_q - 1'b1;
  assign tmo     = state_q == BURST && !gv && load && idle_q == IW'(TIMEOUT - 1);
  assign nxt     = gnt_q == PORT_W'(NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
  assign in_ack  = (state_q == BURST && load) ? (NUM_PORTS'(gv) << gnt_q) : '0;
  assign out_vld     = vld_q;
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign out_last    = last_q;
  assign busy        = state_q != IDLE;
  assign err_timeout = err_q;
  // valid port with the smallest distance above rr_q (wrapping) wins
  always_comb begin
    pick = '0;
    best = NUM_PORTS;
    off  = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      off = p >= int'(rr_q) ? p - int'(rr_q) : p + NUM_PORTS - int'(rr_q);
      if (in_vld[p] && off < best) begin
        best = off;
        pick = PORT_W'(p);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    vld_d   = load ? xfer : vld_q;
    last_d  = load ? xfer && is_last : last_q;
    data_d  = xfer ? in_data[int'(gnt_q)*DATA_W +: DATA_W] : data_q;
    src_d   = xfer ? gnt_q : src_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: state_d = |in_vld ? ARB : IDLE;
      ARB: begin
        state_d = |in_vld ? BURST : IDLE;
        if (|in_vld) begin
          gnt_d  = pick;
          blen_d = cfg_burst_len == '0 ? BLEN_W'(1) : cfg_burst_len;
          beat_d = '0;
          idle_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
          if (is_last) begin
            rr_d    = nxt;
            state_d = |in_vld ? ARB : IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          rr_d    = nxt;
          state_d = ARB;
        end else if (load) begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_hmc_pfch_rd_arb.sv
// tb_hmc_pfch_rd_arb: scoreboard bench for hmc_pfch_rd_arb with a transaction-level arbitration model
module tb_hmc_pfch_rd_arb;
  localparam int N = 4, DW = 64, BW = 8, TO = 16, PW = 2;
  logic clk = 0, rst = 1;
  logic [N-1:0] in_vld = '0, in_ack;
  logic [N*DW-1:0] in_data = '0;
  logic [BW-1:0] cfg = '0;
  logic out_vld, out_last, out_rdy = 0, busy, err_timeout;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_src;
  typedef struct {int src; logic [DW-1:0] data; logic last;} beat_t;
  beat_t sbq[$];
  int tests = 0, fails = 0, err_seen = 0;
  int seq[N];
  int m_st, m_g, m_rr, m_blen, m_beats, m_idle;
  logic m_ovld, m_olast, m_err;
  hmc_pfch_rd_arb #(.NUM_PORTS(N), .DATA_W(DW), .BLEN_W(BW), .TIMEOUT(TO), .PORT_W(PW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_ack(in_ack),
    .cfg_burst_len(cfg), .out_vld(out_vld), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_rdy(out_rdy), .busy(busy), .err_timeout(err_timeout));
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] pat(int p, int s);
    return {8'(p), 24'(s), 32'(s * 7 + p) ^ 32'hC0DE_0000};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_g = 0; m_rr = 0; m_blen = 1; m_beats = 0; m_idle = 0;
    m_ovld = 0; m_olast = 0; m_err = 0;
    sbq.delete();
  endtask
  // one clock of stimulus; the model predicts acks, pushes accepted beats and tracks the output register
  task automatic cycle(logic [N-1:0] v, logic r, logic [BW-1:0] c);
    logic [N-1:0] ack;
    logic load, last;
    int n;
    in_vld = v; out_rdy = r; cfg = c;
    for (int p = 0; p < N; p++) in_data[p*DW +: DW] = pat(p, seq[p]);
    @(negedge clk);
    chk("out_vld", out_vld, m_ovld);
    chk("out_last", out_last, m_olast);
    chk("busy", busy, m_st != 0);
    chk("err_timeout", err_timeout, m_err);
    load = !m_ovld || r;
    ack = '0; last = 0; m_err = 0; n = m_st;
    if (m_st == 0) n = (v != 0) ? 1 : 0;
    else if (m_st == 1) begin
      if (v != 0) begin
        for (int i = 0; i < N; i++) if (v[(m_rr + i) % N]) begin m_g = (m_rr + i) % N; break; end
        m_blen = (c == 0) ? 1 : int'(c);
        m_beats = 0; m_idle = 0; n = 2;
      end else n = 0;
    end else if (load && v[m_g]) begin
      ack[m_g] = 1;
      m_beats++;
      last = m_beats == m_blen;
      sbq.push_back('{m_g, pat(m_g, seq[m_g]), last});
      seq[m_g]++;
      m_idle = 0;
      if (last) begin m_rr = (m_g + 1) % N; n = (v != 0) ? 1 : 0; end
    end else if (load) begin
      m_idle++;
      if (m_idle == TO) begin m_err = 1; m_rr = (m_g + 1) % N; n = 1; end
    end
    chk("in_ack", in_ack, ack);
    if (load) begin m_ovld = ack != 0; m_olast = last; end
    m_st = n;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1;
    in_vld = '0; out_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  always @(negedge clk) begin
    beat_t e;
    if (!rst && err_timeout) err_seen++;
    if (!rst && out_vld && out_rdy) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard: unexpected beat src=%0d data=%0h, none expected", out_src, out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_src", out_src, e.src);
        chk("out_data", out_data, e.data);
        chk("out_last_beat", out_last, e.last);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
  initial begin
    int s0, e0, k;
    for (int p = 0; p < N; p++) seq[p] = p * 1000;
    model_reset();
    #2;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    do_reset();
    for (int i = 0; i < 24; i++) cycle(4'b0100, 1, 4);
    for (int i = 0; i < 24; i++) cycle(4'b1111, 1, 2);
    for (int i = 0; i < 6; i++) cycle(4'b0000, 1, 2);
    for (int i = 0; i < 30; i++) cycle(4'b0010, 1'(i % 2), 8);
    for (int i = 0; i < 6; i++) cycle(4'b0000, 1, 8);
    do_reset();
    s0 = seq[0];
    k = 0;
    while (seq[0] - s0 < 3 && k < 20) begin cycle(4'b1001, 1, 8); k++; end
    chk("timeout_setup_acks", seq[0] - s0, 3);
    e0 = err_seen;
    for (int i = 0; i < 24; i++) cycle(4'b1000, 1, 8);
    chk("timeout_pulses", err_seen - e0, 1);
    for (int i = 0; i < 6; i++) cycle(4'b0000, 1, 8);
    for (int i = 0; i < 16; i++) cycle(4'b0011, 1, 0);
    for (int i = 0; i < 500; i++)
      cycle(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, BW'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++)
      cycle(N'(($urandom_range(0, 7) == 0) << $urandom_range(0, 3)), $urandom_range(0, 2) != 0,
            BW'($urandom_range(0, 5)));
    for (int i = 0; i < 8; i++) cycle(4'b0000, 1, 2);
    chk("drain_empty", sbq.size(), 0);
    k = 0;
    while (!out_vld && k < 10) begin cycle(4'b1111, 1, 3); k++; end
    chk("pre_reset_out_vld", out_vld, 1);
    #2 rst = 1;
    #1;
    chk("async_out_vld", out_vld, 0);
    chk("async_out_data", out_data, 0);
    chk("async_out_src", out_src, 0);
    chk("async_out_last", out_last, 0);
    chk("async_in_ack", in_ack, 0);
    chk("async_busy", busy, 0);
    chk("async_err", err_timeout, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 16; i++) cycle(4'b1111, 1, 2);
    for (int i = 0; i < 8; i++) cycle(4'b0000, 1, 2);
    chk("final_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
